alu_muldiv_seq: RTL
===================

Name: alu_muldiv_seq

Overview:
Multi-cycle sequencer that runs 8x8 unsigned multiply on the existing 8-bit ALU, and optionally 8/8 unsigned divide.
- Owns the operand, accumulator and quotient registers and drives the ALU's operand and control inputs.
- Reads the ALU result from dbus and the carry from flagCarry.
- Sits beside the ALU in the CPU datapath; the control unit starts it with a start/busy/done handshake.

Parameters:
ITERS, 8, number of shift/add iterations; equals the operand width and is fixed at 8 for this datapath.

Ports:
clk  in  1  system clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset.
start  in  1  request; sampled only in IDLE.
op  in  1  0 = multiply, 1 = divide.
aIn  in  8  multiplicand or dividend.
bIn  in  8  multiplier or divisor.
busy  out  1  high from the cycle after an accepted start through DONE.
done  out  1  one-cycle pulse in DONE.
err  out  1  valid with done; divide-by-zero or unsupported op.
resultHi  out  8  product high byte or remainder; held until the next accepted start.
resultLo  out  8  product low byte or quotient; held until the next accepted start.
areg  out  8  ALU A operand.
breg  out  8  ALU B operand.
doSubtract  out  1  ALU subtract select.
assertBarE  out  1  active-low enable for the ALU E-path onto dbus.
assertBarS  out  1  ALU shift-path enable; tied to 1, never driven low.
triggerC  out  1  carry-capture strobe; registered one-cycle pulse.
dbus  in  8  ALU result.
flagCarry  in  1  ALU carry flag.

Behaviour:
Reset:
- State goes to IDLE.
- busy=0, done=0, err=0, resultHi=0, resultLo=0, areg=0, breg=0, doSubtract=0, assertBarE=1, triggerC=0.
- Reset mid-operation aborts immediately; no done pulse is produced.

States: IDLE, OPA, CAP, STEP, DONE.

IDLE, on start:
- Latch B=bIn and iteration count n=0.
- Multiply: A=0, Q=aIn.
- Divide: R=0, rmsb=0, Q=aIn, then perform the first left shift {rmsb,R,Q}<<=1.
- Go to OPA.

OPA (operands driven; outputs registered, stable for the whole cycle):
- Multiply: areg=A, breg=B, doSubtract=0, assertBarE=~Q[0].
- Divide: areg=R, breg=B, doSubtract=1, assertBarE=0.

CAP:
- Operands held; triggerC=1 for this cycle only, so flagCarry samples stable operands.
- At the end of CAP, latch T=dbus if assertBarE=0.

STEP (assertBarE=1, triggerC=0):
- Multiply: c = flagCarry & Q[0]; if Q[0], A=T; then {A,Q} = {c,A,Q}>>1.
- Divide: ok = flagCarry | rmsb (flagCarry=1 means no borrow). If ok, R=T and Q[0]=1. Then, if n<7, shift {rmsb,R,Q}<<=1.
- n++. If n==8 go to DONE, else go to OPA.

DONE:
- done=1 and busy=1 for one cycle.
- Multiply: resultHi=A, resultLo=Q.
- Divide: resultHi=R, resultLo=Q.
- Then go to IDLE.

Timing and handshake:
- Start-to-done latency is 25 cycles (8x3 + 1).
- done occurs exactly 25 clocks after the start-sampling edge.
- start while busy is ignored.

Arithmetic and boundary rules:
- All arithmetic is 8-bit modulo.
- Divide: when rmsb=1 the subtract always commits; the 8-bit dbus value is exact because the true difference is < 256.
- Divide by zero (bIn=0, op=1): go straight from IDLE to DONE (latency 1). err=1, resultHi=aIn, resultLo=0xFF.

Optional Feature:
Macro ALU_MULDIV_SEQ_DIV_EN.
- Defined: the divide path above is present.
- Undefined: op=1 goes IDLE to DONE with err=1, resultHi=0, resultLo=0. Divide-only registers (rmsb, divide muxing) are removed. Multiply is unchanged.

Decomposition:
Shared package alu_seq_pkg:
- State enum (IDLE, OPA, CAP, STEP, DONE).
- OP_MUL=0 and OP_DIV=1.
- ITERS constant.
- DIV0_QUOTIENT = 0xFF.

Single module; no natural sub-module. The bench instantiates the existing ALU alongside it, with areg, breg and the control strobes wired across.

Test Plan:
- mul 13*11 (aIn=0x0D, bIn=0x0B) -> done at +25 cycles, resultHi=0x00, resultLo=0x8F, err=0.
- mul 255*255 -> resultHi=0xFE, resultLo=0x01; 0*200 -> 0x0000; assertBarS stays 1 throughout.
- div 200/7 (with _EN) -> resultLo=0x1C, resultHi=0x04; div 255/1 -> 0xFF r 0x00; div 5/9 -> 0x00 r 0x05.
- div 42/0 -> done 1 cycle after start, err=1, resultHi=0x2A, resultLo=0xFF. Without _EN, any op=1 -> err=1, results 0x00.
- start pulsed again at cycle 10 of a multiply -> ignored; the first result is correct and there is exactly one done pulse.
- reset asserted at cycle 12 of an operation -> next cycle IDLE, busy=0, results 0x00, assertBarE=1; a new start then completes normally.

Source files
------------

// File: rtl/alu_seq_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the ALU multiply/divide sequencer.
package alu_seq_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ITERS  = 8;
    localparam int unsigned CNT_W  = 4;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    localparam logic [DATA_W-1:0] DIV0_QUOTIENT = 8'hFF;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        OPA  = 3'd1,
        CAP  = 3'd2,
        STEP = 3'd3,
        DONE = 3'd4
    } state_e;

endpackage

// File: rtl/alu_muldiv_seq.sv
`timescale 1ns/1ps
// Sequences the shared 8-bit ALU through shift/add multiply and restoring divide.
// The divide path exists only when ALU_MULDIV_SEQ_DIV_EN is defined.
module alu_muldiv_seq
    import alu_seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              op,
    input  logic [DATA_W-1:0] aIn,
    input  logic [DATA_W-1:0] bIn,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] resultHi,
    output logic [DATA_W-1:0] resultLo,
    output logic [DATA_W-1:0] areg,
    output logic [DATA_W-1:0] breg,
    output logic              doSubtract,
    output logic              assertBarE,
    output logic              assertBarS,
    output logic              triggerC,
    input  logic [DATA_W-1:0] dbus,
    input  logic              flagCarry
);

    state_e state_q, state_d;

    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] t_q, t_d;
    logic [CNT_W-1:0]  n_q, n_d;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] res_hi_q, res_hi_d;
    logic [DATA_W-1:0] res_lo_q, res_lo_d;
    logic [DATA_W-1:0] areg_q, areg_d;
    logic [DATA_W-1:0] breg_q, breg_d;
    logic              dosub_q, dosub_d;
    logic              bare_q, bare_d;
    logic              trig_q, trig_d;

    logic              mul_c;
    logic [DATA_W-1:0] mul_a;

`ifdef ALU_MULDIV_SEQ_DIV_EN
    logic              op_q, op_d;
    logic              rmsb_q, rmsb_d;
    logic              div_ok;
    logic [DATA_W-1:0] div_r;
    logic [DATA_W-1:0] div_q;
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            quo_q    <= '0;
            b_q      <= '0;
            t_q      <= '0;
            n_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            areg_q   <= '0;
            breg_q   <= '0;
            dosub_q  <= 1'b0;
            bare_q   <= 1'b1;
            trig_q   <= 1'b0;
`ifdef ALU_MULDIV_SEQ_DIV_EN
            op_q     <= OP_MUL;
            rmsb_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            quo_q    <= quo_d;
            b_q      <= b_d;
            t_q      <= t_d;
            n_q      <= n_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            areg_q   <= areg_d;
            breg_q   <= breg_d;
            dosub_q  <= dosub_d;
            bare_q   <= bare_d;
            trig_q   <= trig_d;
`ifdef ALU_MULDIV_SEQ_DIV_EN
            op_q     <= op_d;
            rmsb_q   <= rmsb_d;
`endif
        end
    end

    // Next state, datapath update and next registered outputs
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        quo_d    = quo_q;
        b_d      = b_q;
        t_d      = t_q;
        n_d      = n_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        areg_d   = areg_q;
        breg_d   = breg_q;
        dosub_d  = dosub_q;
        bare_d   = 1'b1;
        trig_d   = 1'b0;
        mul_c    = 1'b0;
        mul_a    = '0;
`ifdef ALU_MULDIV_SEQ_DIV_EN
        op_d     = op_q;
        rmsb_d   = rmsb_q;
        div_ok   = 1'b0;
        div_r    = '0;
        div_q    = '0;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    b_d    = bIn;
                    n_d    = '0;
                    busy_d = 1'b1;
                    err_d  = 1'b0;
                    if (op == OP_MUL) begin
`ifdef ALU_MULDIV_SEQ_DIV_EN
                        op_d    = OP_MUL;
`endif
                        acc_d   = '0;
                        quo_d   = aIn;
                        state_d = OPA;
                        areg_d  = '0;
                        breg_d  = bIn;
                        dosub_d = 1'b0;
                        bare_d  = ~aIn[0];
                    end else begin
`ifdef ALU_MULDIV_SEQ_DIV_EN
                        op_d = OP_DIV;
                        if (bIn == '0) begin
                            state_d  = DONE;
                            done_d   = 1'b1;
                            err_d    = 1'b1;
                            res_hi_d = aIn;
                            res_lo_d = DIV0_QUOTIENT;
                        end else begin
                            // First left shift of {rmsb,R,Q} folded into the load
                            rmsb_d  = 1'b0;
                            acc_d   = {(DATA_W-1)'(0), aIn[DATA_W-1]};
                            quo_d   = {aIn[DATA_W-2:0], 1'b0};
                            state_d = OPA;
                            areg_d  = {(DATA_W-1)'(0), aIn[DATA_W-1]};
                            breg_d  = bIn;
                            dosub_d = 1'b1;
                            bare_d  = 1'b0;
                        end
`else
                        state_d  = DONE;
                        done_d   = 1'b1;
                        err_d    = 1'b1;
                        res_hi_d = '0;
                        res_lo_d = '0;
`endif
                    end
                end
            end

            OPA: begin
                state_d = CAP;
                trig_d  = 1'b1;
                bare_d  = bare_q;
            end

            CAP: begin
                state_d = STEP;
                if (!bare_q) begin
                    t_d = dbus;
                end
            end

            STEP: begin
                mul_c = flagCarry & quo_q[0];
                mul_a = quo_q[0] ? t_q : acc_q;
                acc_d = {mul_c, mul_a[DATA_W-1:1]};
                quo_d = {mul_a[0], quo_q[DATA_W-1:1]};
`ifdef ALU_MULDIV_SEQ_DIV_EN
                if (op_q == OP_DIV) begin
                    // flagCarry high means no borrow; rmsb forces the commit
                    div_ok = flagCarry | rmsb_q;
                    div_r  = div_ok ? t_q : acc_q;
                    div_q  = div_ok ? {quo_q[DATA_W-1:1], 1'b1} : quo_q;
                    if (n_q < CNT_W'(ITERS - 1)) begin
                        rmsb_d = div_r[DATA_W-1];
                        acc_d  = {div_r[DATA_W-2:0], div_q[DATA_W-1]};
                        quo_d  = {div_q[DATA_W-2:0], 1'b0};
                    end else begin
                        rmsb_d = 1'b0;
                        acc_d  = div_r;
                        quo_d  = div_q;
                    end
                end
`endif
                n_d = n_q + CNT_W'(1);
                if (n_d == CNT_W'(ITERS)) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    res_hi_d = acc_d;
                    res_lo_d = quo_d;
                end else begin
                    state_d = OPA;
                    areg_d  = acc_d;
                    breg_d  = b_q;
                    dosub_d = 1'b0;
                    bare_d  = ~quo_d[0];
`ifdef ALU_MULDIV_SEQ_DIV_EN
                    if (op_q == OP_DIV) begin
                        dosub_d = 1'b1;
                        bare_d  = 1'b0;
                    end
`endif
                end
            end

            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign resultHi   = res_hi_q;
    assign resultLo   = res_lo_q;
    assign areg       = areg_q;
    assign breg       = breg_q;
    assign doSubtract = dosub_q;
    assign assertBarE = bare_q;
    assign assertBarS = 1'b1;
    assign triggerC   = trig_q;

endmodule
